// File: rtl/uar_pkg.sv
// Shared definitions for the UART command controller: FSM states, frame
// constants and motor command encodings.
package uar_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_ARG = 3'd2,
        GET_CHK = 3'd3,
        APPLY   = 3'd4
    } uar_state_t;

    localparam logic [7:0] HDR_BYTE  = 8'hAA;

    localparam logic [7:0] CMD_STOP  = 8'h01;
    localparam logic [7:0] CMD_FWD   = 8'h02;
    localparam logic [7:0] CMD_BACK  = 8'h03;
    localparam logic [7:0] CMD_LEFT  = 8'h04;
    localparam logic [7:0] CMD_RIGHT = 8'h05;
    localparam logic [7:0] CMD_SPEED = 8'h10;
    localparam logic [7:0] CMD_LED   = 8'h20;

    localparam logic [2:0] MOTOR_STOP  = 3'd0;
    localparam logic [2:0] MOTOR_FWD   = 3'd1;
    localparam logic [2:0] MOTOR_BACK  = 3'd2;
    localparam logic [2:0] MOTOR_LEFT  = 3'd3;
    localparam logic [2:0] MOTOR_RIGHT = 3'd4;

    function automatic logic cmd_known(input logic [7:0] cmd);
        case (cmd)
            CMD_STOP, CMD_FWD, CMD_BACK, CMD_LEFT, CMD_RIGHT,
            CMD_SPEED, CMD_LED: cmd_known = 1'b1;
            default:            cmd_known = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] motor_of(input logic [7:0] cmd);
        case (cmd)
            CMD_FWD:   motor_of = MOTOR_FWD;
            CMD_BACK:  motor_of = MOTOR_BACK;
            CMD_LEFT:  motor_of = MOTOR_LEFT;
            CMD_RIGHT: motor_of = MOTOR_RIGHT;
            default:   motor_of = MOTOR_STOP;
        endcase
    endfunction

endpackage

// File: rtl/uar_timeout.sv
// Saturating down-counter with synchronous reload; expired is high while
// the count sits at zero.
module uar_timeout #(
    parameter int unsigned LOAD = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic reload,
    output logic expired
);

    localparam int unsigned W = (LOAD < 1) ? 1 : $clog2(LOAD + 1);
    localparam logic [W-1:0] LOAD_V = W'(LOAD);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= LOAD_V;
        end else if (reload) begin
            count <= LOAD_V;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/uar_cmd_ctrl.sv
// Frame parser for AA/CMD/ARG/CHK command frames from a UART driver, with
// an inter-byte gap timeout and a link watchdog that stops the motor.
module uar_cmd_ctrl
    import uar_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned LINK_TO_MS = 500,
    parameter int unsigned GAP_TO_MS  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_rq,
    output logic [2:0] motor_cmd,
    output logic [7:0] speed,
    output logic [7:0] led,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       link_lost
);

    localparam int unsigned GAP_LOAD  = CLK_HZ / 1000 * GAP_TO_MS;
    localparam int unsigned LINK_LOAD = CLK_HZ / 1000 * LINK_TO_MS;

    uar_state_t state, next_state;
    logic [1:0] rq_sr;
    logic       accept;
    logic [7:0] cmd_q, arg_q;
    logic       chk_ok;
    logic       err_set;
    logic       gap_expired, wd_expired;

    assign accept = (rq_sr == 2'b01);
    assign chk_ok = (rx_data == (cmd_q ^ arg_q)) && cmd_known(cmd_q);

    uar_timeout #(.LOAD(GAP_LOAD)) u_gap (
        .clk     (clk),
        .reset   (reset),
        .enable  (state != IDLE),
        .reload  (accept),
        .expired (gap_expired)
    );

    uar_timeout #(.LOAD(LINK_LOAD)) u_link (
        .clk     (clk),
        .reset   (reset),
        .enable  (!link_lost),
        .reload  (state == APPLY),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rq_sr <= 2'b00;
        end else begin
            state <= next_state;
            rq_sr <= {rq_sr[0], rx_rq};
        end
    end

    // A byte accept always takes priority over a gap expiry in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && (rx_data == HDR_BYTE)) next_state = GET_CMD;
            GET_CMD: if (accept) next_state = GET_ARG;
                     else if (gap_expired) next_state = IDLE;
            GET_ARG: if (accept) next_state = GET_CHK;
                     else if (gap_expired) next_state = IDLE;
            GET_CHK: if (accept) next_state = chk_ok ? APPLY : IDLE;
                     else if (gap_expired) next_state = IDLE;
            APPLY:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = (state == APPLY);
        err_set   = 1'b0;
        case (state)
            GET_CMD, GET_ARG: err_set = !accept && gap_expired;
            GET_CHK:          err_set = accept ? !chk_ok : gap_expired;
            default:          err_set = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && (state == GET_CMD)) cmd_q <= rx_data;
        if (accept && (state == GET_ARG)) arg_q <= rx_data;
    end

    // APPLY wins over a coinciding watchdog expiry, so link_lost stays low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            motor_cmd <= MOTOR_STOP;
            speed     <= 8'd0;
            led       <= 8'd0;
            frame_err <= 1'b0;
            link_lost <= 1'b0;
        end else begin
            frame_err <= err_set;
            if (state == APPLY) begin
                link_lost <= 1'b0;
                case (cmd_q)
                    CMD_STOP, CMD_FWD, CMD_BACK, CMD_LEFT, CMD_RIGHT:
                        motor_cmd <= motor_of(cmd_q);
                    CMD_SPEED: speed <= arg_q;
                    CMD_LED:   led   <= arg_q;
                    default:   ;
                endcase
            end else if (wd_expired) begin
                link_lost <= 1'b1;
                motor_cmd <= MOTOR_STOP;
                speed     <= 8'd0;
            end
        end
    end

endmodule

// File: doc/uar_cmd_ctrl.md
UAR_CMD_CTRL -- requirements
Module: uar_cmd_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter LINK_TO_MS, default 500, link watchdog timeout in ms.
REQ-003 SHALL have parameter GAP_TO_MS, default 10, maximum gap between bytes inside one frame, in ms.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_data  input  8  received byte from the UART driver; valid when rx_rq rises.
REQ-007 SHALL have port rx_rq  input  1  UART byte-ready request; a 0->1 transition marks a new byte.
REQ-008 SHALL have port motor_cmd  output  3  drive command: 0 STOP, 1 FWD, 2 BACK, 3 LEFT, 4 RIGHT.
REQ-009 SHALL have port speed  output  8  PWM duty setpoint.
REQ-010 SHALL have port led  output  8  status LED pattern.
REQ-011 SHALL have port cmd_valid  output  1  one-cycle pulse for each applied frame.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse for each rejected frame.
REQ-013 SHALL have port link_lost  output  1  level; high while the watchdog has expired.

Function
REQ-014 SHALL sample rx_rq into a 2-bit shift register; a byte is accepted in the cycle the register equals 2'b01; rx_data is captured on that same edge.
REQ-015 SHALL parse frames as 0xAA header, CMD, ARG, CHK, where CHK = CMD XOR ARG.
REQ-016 SHALL implement the FSM states IDLE, GET_CMD, GET_ARG, GET_CHK and APPLY.
REQ-017 SHALL, in IDLE, move to GET_CMD only on an accepted byte of 0xAA; any other byte is discarded silently.
REQ-018 SHALL, in GET_CMD, GET_ARG and GET_CHK, store the accepted byte and advance one state per byte; 0xAA is treated as plain data there, with no resynchronisation.
REQ-019 SHALL, in GET_CHK, go to APPLY if CHK matches and CMD is known; otherwise pulse frame_err in the next cycle and return to IDLE.
REQ-020 SHALL treat these CMD codes as known: 0x01 STOP, 0x02 FWD, 0x03 BACK, 0x04 LEFT, 0x05 RIGHT (motor_cmd updated, ARG ignored), 0x10 speed<=ARG, 0x20 led<=ARG.
REQ-021 SHALL, in APPLY, update the outputs, pulse cmd_valid for exactly one cycle, reload the link watchdog, clear link_lost and return to IDLE; latency from the CHK-byte accept cycle to cmd_valid high is 1 cycle.
REQ-022 SHALL keep a gap counter that reloads to CLK_HZ/1000*GAP_TO_MS on every accepted byte and counts only outside IDLE.
REQ-023 SHALL, when the gap counter reaches 0, pulse frame_err and return to IDLE.
REQ-024 SHALL keep a link watchdog that counts down from CLK_HZ/1000*LINK_TO_MS; it reloads only in APPLY.
REQ-025 SHALL, when the watchdog reaches 0, set link_lost=1, force motor_cmd=STOP and speed=0, and leave led unchanged.
REQ-026 SHALL keep the watchdog saturated at 0 while link_lost=1.
REQ-027 SHALL let a byte accept win when it coincides with gap expiry in the same cycle; the byte is processed and the counter reloads.
REQ-028 SHALL let APPLY win when it coincides with watchdog expiry; link_lost stays 0.
REQ-029 SHALL size both counters as ceil(log2(load+1)) bits; counter arithmetic never wraps.
REQ-030 SHALL hold every output between events; the only exceptions are the pulses, which self-clear.

Reset
REQ-031 SHALL, on asserting reset (low), immediately set: FSM=IDLE, motor_cmd=0, speed=0, led=0, cmd_valid=0, frame_err=0, link_lost=0, rx_rq shift register=2'b00, watchdog=full load, gap counter=full load.
REQ-032 SHALL abandon any frame in progress when reset asserts mid-frame, with no frame_err pulse.
REQ-033 SHALL release reset without a rx_rq edge being generated by the release.

Structure
REQ-034 SHALL place the FSM state typedef, the CMD code constants, the header constant 0xAA and the motor_cmd encodings in the shared package uar_pkg.
REQ-035 SHALL implement the two down-counters as one reusable sub-module, uar_timeout (load, enable, reload, expired), instantiated twice.

Verification (CLK_HZ=1000, LINK_TO_MS=20, GAP_TO_MS=5 for simulation)
REQ-036 SHALL cover: frame AA 02 00 02 -> motor_cmd=1, cmd_valid high 1 cycle after the CHK accept, frame_err=0.
REQ-037 SHALL cover: frame AA 10 80 90 -> speed=0x80, motor_cmd unchanged; then AA 20 5A 7A -> led=0x5A.
REQ-038 SHALL cover: frame AA 02 00 03 (bad CHK), then AA 07 00 07 (unknown CMD) -> frame_err pulsed once per frame, no output change.
REQ-039 SHALL cover: AA 03, then no bytes for 6 cycles -> frame_err pulse at the gap expiry, FSM back in IDLE; a following AA 03 00 03 -> motor_cmd=2.
REQ-040 SHALL cover: after FWD at speed 0x80, no frames for 20 cycles -> link_lost=1, motor_cmd=0, speed=0, led held; the next valid frame clears link_lost.
REQ-041 SHALL cover: reset asserted after AA 04 -> all outputs 0 at once; after release, frame 04 00 04 alone is discarded (no header), no pulses.
